// File: rtl/l1_cache_pkg.sv
// Shared types and geometry for the per-core direct-mapped write-through L1.
// Address layout: [tag | index | 2-bit byte offset]; one 32-bit word per line.
package l1_cache_pkg;

  localparam int NUM_LINES = 64;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int TAG_W     = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:IDX_W+2];
  endfunction

endpackage

// File: rtl/l1_tag_data_array.sv
// Valid/tag/data storage: one combinational read port, one fill/update write
// port and one tag-qualified invalidate port that wins over a same-index write.
module l1_tag_data_array
  import l1_cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output line_t            rd_line,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  line_t            wr_line,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic [TAG_W-1:0] inv_tag
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    data_q [NUM_LINES];
  logic                 inv_hit;

  always_comb begin
    rd_line.valid = valid_q[rd_idx];
    rd_line.tag   = tag_q[rd_idx];
    rd_line.data  = data_q[rd_idx];
  end

  // A write landing on the snooped index this cycle defines the line's final
  // tag, so the snoop is matched against that incoming tag instead of storage.
  always_comb begin
    inv_hit = 1'b0;
    if (wr_en && (wr_idx == inv_idx))
      inv_hit = inv_en && (wr_line.tag == inv_tag);
    else
      inv_hit = inv_en && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_q <= '0;
    end else begin
      if (wr_en)   valid_q[wr_idx]  <= wr_line.valid;
      if (inv_hit) valid_q[inv_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_line.tag;
      data_q[wr_idx] <= wr_line.data;
    end
  end

endmodule

// File: rtl/unified_l1_cache.sv
// Per-core direct-mapped write-through L1 with remote-snoop invalidation.
// rst_n is active-high despite its name: rst_n=1 on a rising edge resets.
module unified_l1_cache
  import l1_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy,
  input  logic              core_id,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              snoop_source_id,
  output logic              snoop_ack,
  output logic              l2_req_valid,
  output logic              l2_req_wr,
  output logic [ADDR_W-1:0] l2_req_addr,
  output logic [DATA_W-1:0] l2_req_wdata,
  input  logic              l2_resp_valid,
  input  logic [DATA_W-1:0] l2_resp_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  line_t             rd_line;
  line_t             wr_line;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              hit;
  logic              accept;
  logic              unused_bits;

  assign unused_bits = ^{req_addr[1:0], snoop_addr[1:0]};

  l1_tag_data_array u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (addr_idx(req_addr)),
    .rd_line (rd_line),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_line (wr_line),
    .inv_en  (snoop_valid && (snoop_source_id != core_id)),
    .inv_idx (addr_idx(snoop_addr)),
    .inv_tag (addr_tag(snoop_addr))
  );

  assign hit = rd_line.valid && (rd_line.tag == addr_tag(req_addr));

  // Handshake: a request is taken on any edge where req_valid=1 and busy=0;
  // the L2 side holds l2_req_* stable while l2_req_valid=1 until l2_resp_valid.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = addr_idx(req_addr);
    wr_line = '{valid: 1'b1, tag: addr_tag(req_addr), data: req_wdata};
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_wr) begin
            state_d = WR_THRU;
            wr_en   = hit;
          end else if (!hit) begin
            state_d = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        if (l2_resp_valid) begin
          state_d = IDLE;
          wr_en   = 1'b1;
          wr_idx  = addr_idx(addr_q);
          wr_line = '{valid: 1'b1, tag: addr_tag(addr_q), data: l2_resp_rdata};
        end
      end
      WR_THRU: begin
        if (l2_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      snoop_ack  <= 1'b0;
    end else begin
      state_q    <= state_d;
      snoop_ack  <= snoop_valid;
      resp_valid <= 1'b0;
      if (accept) begin
        addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
        wdata_q <= req_wdata;
        if (!req_wr && hit) begin
          resp_valid <= 1'b1;
          resp_rdata <= rd_line.data;
        end
      end
      if ((state_q != IDLE) && l2_resp_valid) begin
        resp_valid <= 1'b1;
        resp_rdata <= (state_q == RD_MISS) ? l2_resp_rdata : wdata_q;
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign l2_req_valid = busy;
  assign l2_req_wr    = (state_q == WR_THRU);
  assign l2_req_addr  = addr_q;
  assign l2_req_wdata = wdata_q;

endmodule

// File: tb/tb_unified_l1_cache.sv
// Randomised bench for unified_l1_cache: a line-level cache model and an L2
// memory model predict every core response and every L2 request.
module tb_unified_l1_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;
  logic        core_id;
  logic        snoop_valid;
  logic [31:0] snoop_addr;
  logic        snoop_source_id;
  logic        snoop_ack;
  logic        l2_req_valid, l2_req_wr;
  logic [31:0] l2_req_addr, l2_req_wdata;
  logic        l2_resp_valid;
  logic [31:0] l2_resp_rdata;

  always #5 clk = ~clk;

  unified_l1_cache dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_wr          (req_wr),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .busy            (busy),
    .core_id         (core_id),
    .snoop_valid     (snoop_valid),
    .snoop_addr      (snoop_addr),
    .snoop_source_id (snoop_source_id),
    .snoop_ack       (snoop_ack),
    .l2_req_valid    (l2_req_valid),
    .l2_req_wr       (l2_req_wr),
    .l2_req_addr     (l2_req_addr),
    .l2_req_wdata    (l2_req_wdata),
    .l2_resp_valid   (l2_resp_valid),
    .l2_resp_rdata   (l2_resp_rdata)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } l2_txn_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  l2_txn_t     l2_q[$];
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_data  [64];
  logic [31:0] l2_mem  [logic [31:0]];
  bit          resp_delay0 = 1'b0;
  bit          l2_hold     = 1'b0;
  bit          late_pulse  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return l2_mem.exists(a) ? l2_mem[a] : (a * 3 + 32'h1357_0000);
  endfunction

  function automatic int lidx(input logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  function automatic logic [31:0] ltag(input logic [31:0] a);
    return a >> 8;
  endfunction

  // Scoreboard monitor: every response must match the oldest prediction.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
      else chk("resp_rdata", resp_rdata, exp_q.pop_front());
    end
  end

  // L2 responder: checks each request against the predicted transaction.
  initial begin : l2_responder
    l2_txn_t e;
    int      d;
    l2_resp_valid = 1'b0;
    l2_resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (late_pulse) begin
        l2_resp_valid = 1'b1;
        l2_resp_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        l2_resp_valid = 1'b0;
        late_pulse    = 1'b0;
      end else if (l2_req_valid && !l2_hold) begin
        if (l2_q.size() == 0) begin
          chk("unexpected_l2_req", {31'd0, l2_req_valid}, 32'd0);
          e.wr = 1'b0; e.addr = l2_req_addr; e.wdata = '0; e.rdata = '0;
        end else begin
          e = l2_q.pop_front();
          chk("l2_wr", {31'd0, l2_req_wr}, {31'd0, e.wr});
          chk("l2_addr", l2_req_addr, e.addr);
          if (e.wr) chk("l2_wdata", l2_req_wdata, e.wdata);
        end
        d = resp_delay0 ? 0 : int'($urandom_range(0, 3));
        repeat (d) @(negedge clk);
        chk("l2_hold_valid", {31'd0, l2_req_valid}, 32'd1);
        chk("l2_hold_addr", l2_req_addr, e.addr);
        l2_resp_valid = 1'b1;
        l2_resp_rdata = e.rdata;
        @(negedge clk);
        l2_resp_valid = 1'b0;
        chk("l2_drop", {31'd0, l2_req_valid}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (l2_q.size() == 0) && !busy && !l2_resp_valid;
    end
    if (!done) begin
      chk("drain_timeout", exp_q.size() + l2_q.size(), 32'd0);
      exp_q.delete();
      l2_q.delete();
    end
  endtask

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input bit snoop_fill);
    int          i;
    bit          hit;
    logic [31:0] wa;
    l2_txn_t     t;
    i   = lidx(addr);
    hit = m_valid[i] && (m_tag[i] == ltag(addr));
    wa  = addr & ~32'h3;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    if (wr) begin
      t.wr = 1'b1; t.addr = wa; t.wdata = wd; t.rdata = $urandom;
      l2_q.push_back(t);
      l2_mem[wa] = wd;
      exp_q.push_back(wd);
      if (hit) m_data[i] = wd;
    end else if (hit) begin
      exp_q.push_back(m_data[i]);
    end else begin
      t.wr = 1'b0; t.addr = wa; t.wdata = '0; t.rdata = mem_rd(wa);
      l2_q.push_back(t);
      exp_q.push_back(t.rdata);
      m_valid[i] = !snoop_fill;
      m_tag[i]   = ltag(addr);
      m_data[i]  = t.rdata;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("l2_req_start", {31'd0, l2_req_valid}, {31'd0, (wr || !hit)});
    if (!wr && hit) chk("hit_latency", {31'd0, resp_valid}, 32'd1);
    if (snoop_fill) begin
      snoop_valid = 1'b1; snoop_addr = addr; snoop_source_id = 1'b1;
      @(negedge clk);
      snoop_valid = 1'b0;
      chk("snoop_ack_fill", {31'd0, snoop_ack}, 32'd1);
    end
    wait_idle();
  endtask

  task automatic do_snoop(input logic [31:0] addr, input logic src);
    int i;
    i = lidx(addr);
    @(negedge clk);
    snoop_valid = 1'b1; snoop_addr = addr; snoop_source_id = src;
    if (src != core_id && m_valid[i] && m_tag[i] == ltag(addr)) m_valid[i] = 1'b0;
    @(negedge clk);
    snoop_valid = 1'b0;
    chk("snoop_ack", {31'd0, snoop_ack}, 32'd1);
    @(negedge clk);
    chk("snoop_ack_pulse", {31'd0, snoop_ack}, 32'd0);
  endtask

  task automatic hit_with_snoop(input logic [31:0] addr);
    int i;
    i = lidx(addr);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = addr;
    snoop_valid = 1'b1; snoop_addr = addr; snoop_source_id = 1'b1;
    exp_q.push_back(m_data[i]);
    m_valid[i] = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; snoop_valid = 1'b0;
    chk("hit_snoop_resp", {31'd0, resp_valid}, 32'd1);
    chk("hit_snoop_ack", {31'd0, snoop_ack}, 32'd1);
    wait_idle();
  endtask

  task automatic burst_hits();
    int lines[$];
    for (int k = 0; k < 64; k++) if (m_valid[k] && lines.size() < 6) lines.push_back(k);
    if (lines.size() < 2) return;
    @(negedge clk);
    foreach (lines[j]) begin
      req_valid = 1'b1; req_wr = 1'b0;
      req_addr  = (m_tag[lines[j]] << 8) | (lines[j] << 2);
      exp_q.push_back(m_data[lines[j]]);
      @(negedge clk);
      chk("burst_resp_valid", {31'd0, resp_valid}, 32'd1);
    end
    req_valid = 1'b0;
    wait_idle();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          r;
    logic [31:0] a;
    rst_n = 1'b1; core_id = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    snoop_valid = 1'b0; snoop_addr = '0; snoop_source_id = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_snoop_ack", {31'd0, snoop_ack}, 32'd0);
    chk("rst_l2_valid", {31'd0, l2_req_valid}, 32'd0);
    chk("rst_l2_wr", {31'd0, l2_req_wr}, 32'd0);
    chk("rst_l2_addr", l2_req_addr, 32'd0);
    chk("rst_l2_wdata", l2_req_wdata, 32'd0);
    rst_n = 1'b0;

    l2_mem[32'h1000] = 32'hDEAD_BEEF;
    do_req(1'b0, 32'h1000, 32'd0, 1'b0);
    do_req(1'b0, 32'h1000, 32'd0, 1'b0);
    do_req(1'b1, 32'h1000, 32'd5, 1'b0);
    do_req(1'b0, 32'h1000, 32'd0, 1'b0);
    do_snoop(32'h1000, 1'b1);
    do_req(1'b0, 32'h1000, 32'd0, 1'b0);
    do_snoop(32'h1000, 1'b0);
    do_req(1'b0, 32'h1000, 32'd0, 1'b0);
    hit_with_snoop(32'h1000);
    do_req(1'b0, 32'h1000, 32'd0, 1'b0);
    resp_delay0 = 1'b1;
    do_req(1'b0, 32'h2004, 32'd0, 1'b1);
    resp_delay0 = 1'b0;
    do_req(1'b0, 32'h2004, 32'd0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      a = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if (r < 40)      do_req(1'b0, a, 32'd0, 1'b0);
      else if (r < 70) do_req(1'b1, a, $urandom, 1'b0);
      else if (r < 88) do_snoop(a, 1'($urandom_range(0, 1)));
      else             burst_hits();
    end

    // Reset in the middle of a read miss abandons it; a late L2 reply is ignored.
    l2_hold = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h3000;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      req_addr = 32'h1000;
      chk("busy_hold", {31'd0, busy}, 32'd1);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_l2_valid", {31'd0, l2_req_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b0;
    for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
    l2_hold = 1'b0;
    late_pulse = 1'b1;
    repeat (4) @(negedge clk);
    chk("late_resp_l2_valid", {31'd0, l2_req_valid}, 32'd0);
    do_req(1'b0, 32'h1000, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
